// File: rtl/core_pkg.sv
// Shared constants for the RV32I core: ALU operation codes and forwarding selects.
package core_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_LUI = 3'b111;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage; code 110 is unassigned and drives zero.
module alu
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CONTROL_WIDTH = 3
) (
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [CONTROL_WIDTH-1:0] ALUControl,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero
);

  logic lt;

  assign lt = $signed(SrcA) < $signed(SrcB);

  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD: ALUResult = SrcA + SrcB;
      ALU_SUB: ALUResult = SrcA - SrcB;
      ALU_AND: ALUResult = SrcA & SrcB;
      ALU_OR:  ALUResult = SrcA | SrcB;
      ALU_SLL: ALUResult = SrcA << SrcB[4:0];
      ALU_SLT: ALUResult = {{(DATA_WIDTH-1){1'b0}}, lt};
      ALU_LUI: ALUResult = SrcB;
      default: ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch/jump resolution and the
// EX/MEM register.
module execute_stage
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CONTROL_WIDTH  = 3,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic                      JumpD,
  input  logic                      BranchD,
  input  logic                      ALUSrcD,
  input  logic [1:0]                ResultSrcD,
  input  logic [CONTROL_WIDTH-1:0]  ALUControlD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic [1:0]                ForwardAE,
  input  logic [1:0]                ForwardBE,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic                      ResultSrcE0,
  output logic                      PCSrcE,
  output logic [DATA_WIDTH-1:0]     PCTargetE,
  output logic                      RegWriteM,
  output logic                      MemWriteM,
  output logic [1:0]                ResultSrcM,
  output logic [DATA_WIDTH-1:0]     ALUResultM,
  output logic [DATA_WIDTH-1:0]     WriteDataM,
  output logic [DATA_WIDTH-1:0]     PCPlus4M,
  output logic [REG_ADDR_WIDTH-1:0] RdM
);

  typedef struct packed {
    logic                      regwrite;
    logic                      memwrite;
    logic                      jump;
    logic                      branch;
    logic                      alusrc;
    logic [1:0]                resultsrc;
    logic [CONTROL_WIDTH-1:0]  alucontrol;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     immext;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pcplus4;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic                      regwrite;
    logic                      memwrite;
    logic [1:0]                resultsrc;
    logic [DATA_WIDTH-1:0]     aluresult;
    logic [DATA_WIDTH-1:0]     writedata;
    logic [DATA_WIDTH-1:0]     pcplus4;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } ex_mem_t;

  id_ex_t  id_ex_d, id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;

  logic [DATA_WIDTH-1:0] src_a_e, src_b_e, write_data_e, alu_result_e;
  logic                  zero_e;

  always_comb begin
    id_ex_d = '{
      regwrite:   RegWriteD,
      memwrite:   MemWriteD,
      jump:       JumpD,
      branch:     BranchD,
      alusrc:     ALUSrcD,
      resultsrc:  ResultSrcD,
      alucontrol: ALUControlD,
      rd1:        RD1D,
      rd2:        RD2D,
      immext:     ImmExtD,
      pc:         PCD,
      pcplus4:    PCPlus4D,
      rs1:        Rs1D,
      rs2:        Rs2D,
      rd:         RdD
    };
  end

  // Flush beats stall so the hazard unit can squash a held instruction.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      id_ex_q <= '0;
    end else if (!StallE) begin
      id_ex_q <= id_ex_d;
    end
  end

  always_comb begin
    src_a_e = id_ex_q.rd1;
    case (ForwardAE)
      FWD_W:   src_a_e = ResultW;
      FWD_M:   src_a_e = ex_mem_q.aluresult;
      default: src_a_e = id_ex_q.rd1;
    endcase
  end

  always_comb begin
    write_data_e = id_ex_q.rd2;
    case (ForwardBE)
      FWD_W:   write_data_e = ResultW;
      FWD_M:   write_data_e = ex_mem_q.aluresult;
      default: write_data_e = id_ex_q.rd2;
    endcase
  end

  assign src_b_e = id_ex_q.alusrc ? id_ex_q.immext : write_data_e;

  alu #(
    .DATA_WIDTH    (DATA_WIDTH),
    .CONTROL_WIDTH (CONTROL_WIDTH)
  ) u_alu (
    .SrcA       (src_a_e),
    .SrcB       (src_b_e),
    .ALUControl (id_ex_q.alucontrol),
    .ALUResult  (alu_result_e),
    .Zero       (zero_e)
  );

  assign PCSrcE    = (id_ex_q.branch & zero_e) | id_ex_q.jump;
  assign PCTargetE = id_ex_q.pc + id_ex_q.immext;

  always_comb begin
    ex_mem_d = '{
      regwrite:  id_ex_q.regwrite,
      memwrite:  id_ex_q.memwrite,
      resultsrc: id_ex_q.resultsrc,
      aluresult: alu_result_e,
      writedata: write_data_e,
      pcplus4:   id_ex_q.pcplus4,
      rd:        id_ex_q.rd
    };
  end

  // A stalled E instruction is re-executed next cycle, so M must see a bubble now.
  always_ff @(posedge clk) begin
    if (rst || (StallE && !FlushE)) begin
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign Rs1E        = id_ex_q.rs1;
  assign Rs2E        = id_ex_q.rs2;
  assign RdE         = id_ex_q.rd;
  assign ResultSrcE0 = id_ex_q.resultsrc[0];

  assign RegWriteM  = ex_mem_q.regwrite;
  assign MemWriteM  = ex_mem_q.memwrite;
  assign ResultSrcM = ex_mem_q.resultsrc;
  assign ALUResultM = ex_mem_q.aluresult;
  assign WriteDataM = ex_mem_q.writedata;
  assign PCPlus4M   = ex_mem_q.pcplus4;
  assign RdM        = ex_mem_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vectors and sequences plus a randomized run scored
// against a per-instruction reference model.
module tb_execute_stage;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic        jump;
    logic        branch;
    logic        alusrc;
    logic [1:0]  resultsrc;
    logic [2:0]  ctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } instr_t;

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic [1:0]  resultsrc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pcp4;
    logic [4:0]  rd;
  } mrec_t;

  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] exp;
  } alu_vec_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [1:0]  fa;
  logic [1:0]  fb;
  logic [31:0] resultw;
  instr_t      d;

  logic [4:0]  rs1_e, rs2_e, rd_e, rd_m;
  logic        rsrc_e0, pcsrc_e, regwrite_m, memwrite_m;
  logic [1:0]  resultsrc_m;
  logic [31:0] pctarget_e, aluresult_m, writedata_m, pcplus4_m;

  instr_t em;
  mrec_t  mm;
  bit     chk_en;
  int     checks;
  int     errors;

  execute_stage dut (
    .clk         (clk),
    .rst         (rst),
    .StallE      (stall),
    .FlushE      (flush),
    .RegWriteD   (d.regwrite),
    .MemWriteD   (d.memwrite),
    .JumpD       (d.jump),
    .BranchD     (d.branch),
    .ALUSrcD     (d.alusrc),
    .ResultSrcD  (d.resultsrc),
    .ALUControlD (d.ctl),
    .RD1D        (d.rd1),
    .RD2D        (d.rd2),
    .ImmExtD     (d.imm),
    .PCD         (d.pc),
    .PCPlus4D    (d.pcp4),
    .Rs1D        (d.rs1),
    .Rs2D        (d.rs2),
    .RdD         (d.rd),
    .ForwardAE   (fa),
    .ForwardBE   (fb),
    .ResultW     (resultw),
    .Rs1E        (rs1_e),
    .Rs2E        (rs2_e),
    .RdE         (rd_e),
    .ResultSrcE0 (rsrc_e0),
    .PCSrcE      (pcsrc_e),
    .PCTargetE   (pctarget_e),
    .RegWriteM   (regwrite_m),
    .MemWriteM   (memwrite_m),
    .ResultSrcM  (resultsrc_m),
    .ALUResultM  (aluresult_m),
    .WriteDataM  (writedata_m),
    .PCPlus4M    (pcplus4_m),
    .RdM         (rd_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] w, input logic [31:0] m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return rf;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
    case (ctl)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a << b[4:0];
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd7: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_wd();
    return pick(fb, em.rd2, resultw, mm.alu);
  endfunction

  function automatic logic [31:0] m_res();
    logic [31:0] a, b;
    a = pick(fa, em.rd1, resultw, mm.alu);
    b = em.alusrc ? em.imm : m_wd();
    return ref_alu(em.ctl, a, b);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] res;
    res = m_res();
    chk("RdE", 32'(rd_e), 32'(em.rd));
    chk("Rs1E", 32'(rs1_e), 32'(em.rs1));
    chk("Rs2E", 32'(rs2_e), 32'(em.rs2));
    chk("ResultSrcE0", 32'(rsrc_e0), 32'(em.resultsrc[0]));
    chk("PCSrcE", 32'(pcsrc_e), 32'((em.branch && res == 32'd0) || em.jump));
    chk("PCTargetE", pctarget_e, em.pc + em.imm);
    chk("RegWriteM", 32'(regwrite_m), 32'(mm.regwrite));
    chk("MemWriteM", 32'(memwrite_m), 32'(mm.memwrite));
    chk("ResultSrcM", 32'(resultsrc_m), 32'(mm.resultsrc));
    chk("ALUResultM", aluresult_m, mm.alu);
    chk("WriteDataM", writedata_m, mm.wd);
    chk("PCPlus4M", pcplus4_m, mm.pcp4);
    chk("RdM", 32'(rd_m), 32'(mm.rd));
  endtask

  // Inputs are set by the caller; compare mid-cycle, then advance the model at the edge.
  task automatic cycle();
    mrec_t nm;
    #2;
    if (chk_en) check_model();
    @(posedge clk);
    nm = '{regwrite: em.regwrite, memwrite: em.memwrite, resultsrc: em.resultsrc,
           alu: m_res(), wd: m_wd(), pcp4: em.pcp4, rd: em.rd};
    if (rst) begin
      em = '0;
      mm = '0;
    end else begin
      mm = (stall && !flush) ? '0 : nm;
      if (flush) em = '0;
      else if (!stall) em = d;
    end
    chk_en = 1'b1;
    #1;
  endtask

  task automatic quiet();
    d = '0; stall = 0; flush = 0; fa = 0; fb = 0; resultw = 0; rst = 0;
  endtask

  task automatic rand_d();
    d.regwrite  = 1'($urandom);
    d.memwrite  = 1'($urandom);
    d.jump      = ($urandom_range(0, 7) == 0);
    d.branch    = 1'($urandom);
    d.alusrc    = 1'($urandom);
    d.resultsrc = 2'($urandom);
    d.ctl       = 3'($urandom);
    d.rd1       = $urandom;
    d.rd2       = $urandom_range(0, 1) ? d.rd1 : $urandom;
    d.imm       = $urandom;
    d.pc        = $urandom;
    d.pcp4      = d.pc + 32'd4;
    d.rs1       = 5'($urandom);
    d.rs2       = 5'($urandom);
    d.rd        = 5'($urandom);
  endtask

  alu_vec_t tbl[8];

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    em = '0;
    mm = '0;
    tbl[0] = '{3'b000, 32'hFFFF_FFF3};
    tbl[1] = '{3'b001, 32'hFFFF_FFED};
    tbl[2] = '{3'b010, 32'h0000_0000};
    tbl[3] = '{3'b011, 32'hFFFF_FFF3};
    tbl[4] = '{3'b100, 32'hFFFF_FF80};
    tbl[5] = '{3'b101, 32'h0000_0001};
    tbl[6] = '{3'b110, 32'h0000_0000};
    tbl[7] = '{3'b111, 32'h0000_0003};

    // Reset with busy D inputs.
    quiet();
    rst = 1;
    rand_d();
    d.jump = 1;
    d.rd = 5'd17;
    cycle();
    cycle();
    rst = 0;
    d = '0;
    chk("reset RdE", 32'(rd_e), 32'd0);
    chk("reset PCSrcE", 32'(pcsrc_e), 32'd0);
    chk("reset PCTargetE", pctarget_e, 32'd0);
    chk("reset RegWriteM", 32'(regwrite_m), 32'd0);
    chk("reset ALUResultM", aluresult_m, 32'd0);

    // ALU sweep.
    foreach (tbl[i]) begin
      quiet();
      d.rd1 = 32'hFFFF_FFF0;
      d.rd2 = 32'h0000_0003;
      d.ctl = tbl[i].ctl;
      cycle();
      d = '0;
      cycle();
      chk($sformatf("alu code %0d", tbl[i].ctl), aluresult_m, tbl[i].exp);
    end

    // Forwarding from M and W, then code 11 selects the register-file operand.
    quiet();
    d.rd1 = 32'd5;
    cycle();
    d.rd1 = 32'hDEAD;
    d.rd2 = 32'hBEEF;
    cycle();
    d.rd1 = 32'h10;
    d.rd2 = 32'h1;
    fa = 2'b10;
    fb = 2'b01;
    resultw = 32'd7;
    cycle();
    chk("fwd M+W ALUResultM", aluresult_m, 32'd12);
    chk("fwd W WriteDataM", writedata_m, 32'd7);
    d = '0;
    fa = 2'b11;
    fb = 2'b00;
    cycle();
    chk("fwd 11 ALUResultM", aluresult_m, 32'h11);

    // Branch taken, not taken, and target wrap.
    quiet();
    d.branch = 1;
    d.ctl = 3'b001;
    d.rd1 = 32'd9;
    d.rd2 = 32'd9;
    d.pc = 32'h100;
    d.imm = 32'h20;
    cycle();
    chk("beq taken PCSrcE", 32'(pcsrc_e), 32'd1);
    chk("beq PCTargetE", pctarget_e, 32'h120);
    d.rd2 = 32'd8;
    cycle();
    chk("beq not taken PCSrcE", 32'(pcsrc_e), 32'd0);
    d.pc = 32'hFFFF_FFF0;
    cycle();
    chk("target wrap", pctarget_e, 32'h10);

    // Stall two cycles, then stall+flush together.
    quiet();
    d.regwrite = 1;
    d.rd = 5'd7;
    d.rs1 = 5'd3;
    cycle();
    stall = 1;
    d.rd = 5'd9;
    d.rs1 = 5'd4;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("stall RdE held", 32'(rd_e), 32'd7);
      chk("stall RegWriteM bubble", 32'(regwrite_m), 32'd0);
      chk("stall RdM bubble", 32'(rd_m), 32'd0);
    end
    flush = 1;
    cycle();
    chk("flush RdE", 32'(rd_e), 32'd0);
    chk("flush Rs1E", 32'(rs1_e), 32'd0);
    chk("flush over stall RdM", 32'(rd_m), 32'd7);

    // Jump.
    quiet();
    d.jump = 1;
    d.regwrite = 1;
    d.pcp4 = 32'h44;
    d.resultsrc = 2'b10;
    d.rd = 5'd1;
    cycle();
    chk("jal PCSrcE", 32'(pcsrc_e), 32'd1);
    d = '0;
    cycle();
    chk("jal PCPlus4M", pcplus4_m, 32'h44);
    chk("jal ResultSrcM", 32'(resultsrc_m), 32'd2);
    chk("jal RegWriteM", 32'(regwrite_m), 32'd1);

    // Randomized run against the model, including occasional mid-run reset.
    for (int n = 0; n < 400; n++) begin
      rand_d();
      rst     = ($urandom_range(0, 49) == 0);
      stall   = ($urandom_range(0, 7) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      fa      = 2'($urandom);
      fb      = 2'($urandom);
      resultw = $urandom;
      cycle();
    end
    quiet();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the pipelined RV32I core.
- Holds the ID/EX pipeline register, the operand-forwarding muxes, the ALU driven by the 3-bit ALUControl code from the decode stage, branch/jump resolution, and the EX/MEM pipeline register.
- Consumes decoded control and operands from decode; feeds the memory stage and the hazard unit.

Parameters:
- DATA_WIDTH, 32, datapath and PC width.
- CONTROL_WIDTH, 3, ALUControl width; must match the decode-stage ALU decoder.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- StallE  input  1  hold the ID/EX register.
- FlushE  input  1  load a bubble into the ID/EX register.
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  input  1 each  decoded control.
- ResultSrcD  input  2  writeback source select.
- ALUControlD  input  CONTROL_WIDTH  ALU operation code.
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  input  DATA_WIDTH each  operands, immediate and PCs.
- Rs1D, Rs2D, RdD  input  REG_ADDR_WIDTH each  register indices.
- ForwardAE, ForwardBE  input  2 each  forwarding selects from the hazard unit.
- ResultW  input  DATA_WIDTH  writeback-stage result.
- Rs1E, Rs2E, RdE  output  REG_ADDR_WIDTH each  registered indices, to the hazard unit.
- ResultSrcE0  output  1  bit 0 of ResultSrcE, for load-use detection.
- PCSrcE  output  1  redirect fetch.
- PCTargetE  output  DATA_WIDTH  branch/jump target.
- RegWriteM, MemWriteM  output  1 each  EX/MEM control.
- ResultSrcM  output  2  EX/MEM writeback source.
- ALUResultM, WriteDataM, PCPlus4M  output  DATA_WIDTH each  EX/MEM data.
- RdM  output  REG_ADDR_WIDTH  EX/MEM destination.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: every E and M register clears to 0 on the first rising edge with rst=1. After reset all outputs are 0; PCSrcE=0 and PCTargetE=0.
- ID/EX update priority: rst > FlushE > StallE > load D inputs.
  - FlushE: all E fields clear to 0 (bubble). Flush wins over a simultaneous StallE.
  - StallE (no flush): E holds its value.
- EX/MEM update priority: rst > (StallE & ~FlushE) > load E results.
  - While E is stalled, M loads a bubble: all M control and data fields are 0, so the held instruction is not duplicated downstream.
- SrcAE from ForwardAE: 00 RD1E, 01 ResultW, 10 ALUResultM, 11 RD1E.
- WriteDataE from ForwardBE, using the same encoding applied to RD2E.
- SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU codes (combinational), results truncated to DATA_WIDTH:
  - 000 add.
  - 001 sub.
  - 010 and.
  - 011 or.
  - 100 sll by SrcBE[4:0].
  - 101 signed slt: result 1 or 0, zero-extended.
  - 111 pass SrcBE (lui).
  - 110 drives 0.
- ZeroE = (ALUResultE == 0).
- PCSrcE = (BranchE & ZeroE) | JumpE.
- PCTargetE = PCE + ImmExtE, modulo 2^DATA_WIDTH (wrap-around, no trap).
- Latency: an instruction accepted in D appears in E one cycle later and in M two cycles later.
- PCSrcE and PCTargetE are combinational from E state. The hazard unit asserts FlushE/FlushD in response; this block does not self-flush.
- Forwarding from M uses the registered ALUResultM. Arbitration is the hazard unit's job; any ForwardXE value is legal.
- Reset mid-operation discards both in-flight instructions in the same cycle.

Decomposition:
- Shared package core_pkg:
  - ALU opcode constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLL=3'b100, ALU_SLT=3'b101, ALU_LUI=3'b111.
  - Forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One combinational sub-module, alu: inputs SrcA, SrcB, ALUControl; outputs ALUResult, Zero.
- Both pipeline registers stay inline in execute_stage.

Test Plan:
- Reset: hold rst 2 cycles with non-zero D inputs -> all M outputs and PCSrcE are 0; RdE=0.
- ALU sweep: RD1D=0xFFFFFFF0, RD2D=0x00000003, ALUSrcD=0, ForwardAE/BE=00. Expected ALUResultM two cycles later per code:
  - 000 -> 0xFFFFFFF3.
  - 001 -> 0xFFFFFFED.
  - 100 -> 0xFFFFFF80.
  - 101 -> 0x00000001.
  - 111 -> 0x00000003.
  - 110 -> 0.
- Forwarding: ForwardAE=10 with ALUResultM=5; ForwardBE=01 with ResultW=7; ALUControl add -> ALUResultM=12 next cycle. ForwardAE=11 -> RD1E is used.
- Branch: BranchD=1, sub, RD1D=RD2D=9, PCD=0x100, ImmExtD=0x20 -> PCSrcE=1, PCTargetE=0x120. With RD2D=8 -> PCSrcE=0. PCD=0xFFFFFFF0 with ImmExtD=0x20 -> PCTargetE=0x10 (wrap).
- Stall then flush: StallE for 2 cycles -> E fields held and M shows bubbles (RegWriteM=0, RdM=0). StallE=FlushE=1 together -> E cleared.
- Jump: JumpD=1, PCPlus4D=0x44, ResultSrcD=10 -> PCSrcE=1; one cycle later PCPlus4M=0x44, ResultSrcM=10, RegWriteM follows RegWriteD.
